// File: rtl/alu_dispatch_pkg.sv
// Shared action-word layout, opcode constants and dispatcher FSM encoding.
package alu_dispatch_pkg;

  // Action word field layout (bit offsets within the action word)
  localparam int OPC_LSB  = 56;
  localparam int OPC_W    = 8;
  localparam int DEST_LSB = 52;
  localparam int SRC1_LSB = 48;
  localparam int SRC2_LSB = 44;
  localparam int SRC3_LSB = 40;
  localparam int IDX_W    = 4;
  localparam int IMM_LSB  = 0;
  localparam int IMM_W    = 32;

  // Opcodes the dispatcher itself has to recognise
  localparam logic [OPC_W-1:0] OP_NOP     = 8'h00;
  localparam logic [OPC_W-1:0] OP_ADD     = 8'h01;
  localparam logic [OPC_W-1:0] OP_ADDI    = 8'h09;
  localparam logic [OPC_W-1:0] OP_IMM_0A  = 8'h0A;
  localparam logic [OPC_W-1:0] OP_IMM_0E  = 8'h0E;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  // Opcodes whose second operand is the immediate rather than a container
  function automatic logic uses_imm(input logic [OPC_W-1:0] opc);
    return (opc == OP_ADDI) || (opc == OP_IMM_0A) || (opc == OP_IMM_0E);
  endfunction

  // Container index reduced modulo the number of containers
  function automatic int unsigned idx_mod(input logic [IDX_W-1:0] idx, input int unsigned n);
    return {{(32-IDX_W){1'b0}}, idx} % n;
  endfunction

endpackage

// File: rtl/alu_dispatch_operand_mux.sv
// Combinational operand selection: PHV containers / immediate -> four ALU operands.
module operand_mux
  import alu_dispatch_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CONT   = 8
) (
  input  logic [NUM_CONT*DATA_WIDTH-1:0] i_phv,
  input  logic [IDX_W-1:0]               i_src1,
  input  logic [IDX_W-1:0]               i_src2,
  input  logic [IDX_W-1:0]               i_src3,
  input  logic [OPC_W-1:0]               i_opcode,
  input  logic [IMM_W-1:0]               i_imm,
  output logic [DATA_WIDTH-1:0]          o_op1,
  output logic [DATA_WIDTH-1:0]          o_op2,
  output logic [DATA_WIDTH-1:0]          o_op3,
  output logic [DATA_WIDTH-1:0]          o_op4
);

  int unsigned           w_s1;
  int unsigned           w_s2;
  int unsigned           w_s3;
  logic [DATA_WIDTH-1:0] w_cont2;

  assign w_s1 = idx_mod(i_src1, NUM_CONT);
  assign w_s2 = idx_mod(i_src2, NUM_CONT);
  assign w_s3 = idx_mod(i_src3, NUM_CONT);

  assign w_cont2 = i_phv[w_s2*DATA_WIDTH +: DATA_WIDTH];

  assign o_op1 = i_phv[w_s1*DATA_WIDTH +: DATA_WIDTH];
  assign o_op2 = uses_imm(i_opcode) ? DATA_WIDTH'(i_imm) : w_cont2;
  assign o_op3 = i_phv[w_s3*DATA_WIDTH +: DATA_WIDTH];
  assign o_op4 = '0;

endmodule

// File: rtl/alu_dispatch.sv
// Single-PHV-in-flight dispatcher: captures a PHV and action, issues the action
// to an external ALU, writes the returned result into the destination container
// and hands the updated PHV downstream. A watchdog bounds the wait for the ALU.
module alu_dispatch
  import alu_dispatch_pkg::*;
#(
  parameter int ACTION_LEN = 64,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CONT   = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CONT*DATA_WIDTH-1:0] phv_in,
  input  logic [ACTION_LEN-1:0]          action_in,
  input  logic                           phv_valid_in,
  output logic                           phv_ready_out,
  output logic [ACTION_LEN-1:0]          alu_action_out,
  output logic                           alu_action_valid,
  output logic [DATA_WIDTH-1:0]          alu_op1_out,
  output logic [DATA_WIDTH-1:0]          alu_op2_out,
  output logic [DATA_WIDTH-1:0]          alu_op3_out,
  output logic [DATA_WIDTH-1:0]          alu_op4_out,
  input  logic                           alu_ready_in,
  input  logic [DATA_WIDTH-1:0]          alu_result_in,
  input  logic                           alu_result_valid_in,
  output logic                           alu_ready_out,
  output logic [NUM_CONT*DATA_WIDTH-1:0] phv_out,
  output logic                           phv_valid_out,
  input  logic                           phv_ready_in,
  output logic                           timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t                         r_state;
  logic [NUM_CONT*DATA_WIDTH-1:0] r_phv;
  logic [ACTION_LEN-1:0]          r_action;
  logic [CNT_W-1:0]               r_cnt;
  logic                           r_phv_ready;
  logic                           r_alu_valid;
  logic                           r_alu_ready;
  logic                           r_phv_valid;
  logic                           r_timeout;

  logic [OPC_W-1:0]               w_in_opcode;
  int unsigned                    w_dest;
  logic [CNT_W-1:0]               w_cnt_next;

  assign w_in_opcode = action_in[OPC_LSB +: OPC_W];
  assign w_dest      = idx_mod(r_action[DEST_LSB +: IDX_W], NUM_CONT);
  assign w_cnt_next  = r_cnt + 1'b1;

  // Operands come straight from the captured PHV/action, so they stay stable
  // for the whole ISSUE/WAIT window without extra registers.
  operand_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_CONT   (NUM_CONT)
  ) u_operand_mux (
    .i_phv    (r_phv),
    .i_src1   (r_action[SRC1_LSB +: IDX_W]),
    .i_src2   (r_action[SRC2_LSB +: IDX_W]),
    .i_src3   (r_action[SRC3_LSB +: IDX_W]),
    .i_opcode (r_action[OPC_LSB +: OPC_W]),
    .i_imm    (r_action[IMM_LSB +: IMM_W]),
    .o_op1    (alu_op1_out),
    .o_op2    (alu_op2_out),
    .o_op3    (alu_op3_out),
    .o_op4    (alu_op4_out)
  );

  // Dispatcher FSM with registered handshake outputs and PHV/action storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_phv_ready <= 1'b1;
      r_alu_valid <= 1'b0;
      r_alu_ready <= 1'b0;
      r_phv_valid <= 1'b0;
      r_timeout   <= 1'b0;
      r_cnt       <= '0;
      r_phv       <= '0;
      r_action    <= '0;
    end else begin
      r_alu_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (phv_valid_in) begin
            r_phv       <= phv_in;
            r_action    <= action_in;
            r_phv_ready <= 1'b0;
            if (w_in_opcode == OP_NOP) begin
              r_phv_valid <= 1'b1;
              r_state     <= ST_OUT;
            end else begin
              r_state     <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (alu_ready_in) begin
            r_alu_valid <= 1'b1;
            r_alu_ready <= 1'b1;
            r_cnt       <= '0;
            r_state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A result on the final allowed cycle still wins over the timeout.
          if (alu_result_valid_in) begin
            r_phv[w_dest*DATA_WIDTH +: DATA_WIDTH] <= alu_result_in;
            r_alu_ready <= 1'b0;
            r_phv_valid <= 1'b1;
            r_state     <= ST_OUT;
          end else if (w_cnt_next == CNT_W'(TIMEOUT)) begin
            r_timeout   <= 1'b1;
            r_alu_ready <= 1'b0;
            r_phv_valid <= 1'b1;
            r_state     <= ST_OUT;
          end else begin
            r_cnt <= w_cnt_next;
          end
        end
        ST_OUT: begin
          if (phv_ready_in) begin
            r_phv_valid <= 1'b0;
            r_phv_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign phv_ready_out    = r_phv_ready;
  assign alu_action_out   = r_action;
  assign alu_action_valid = r_alu_valid;
  assign alu_ready_out    = r_alu_ready;
  assign phv_out          = r_phv;
  assign phv_valid_out    = r_phv_valid;
  assign timeout_err      = r_timeout;

endmodule

// File: tb/tb_alu_dispatch.sv
// Directed plus randomized bench for alu_dispatch with a transaction-level
// reference model of the PHV update and operand selection.
module tb_alu_dispatch;

  localparam int AL = 64;
  localparam int W  = 32;
  localparam int N  = 8;
  localparam int TO = 255;
  localparam int PW = N * W;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] phv_in;
  logic [AL-1:0] action_in;
  logic          phv_valid_in;
  logic          phv_ready_out;
  logic [AL-1:0] alu_action_out;
  logic          alu_action_valid;
  logic [W-1:0]  alu_op1_out;
  logic [W-1:0]  alu_op2_out;
  logic [W-1:0]  alu_op3_out;
  logic [W-1:0]  alu_op4_out;
  logic          alu_ready_in;
  logic [W-1:0]  alu_result_in;
  logic          alu_result_valid_in;
  logic          alu_ready_out;
  logic [PW-1:0] phv_out;
  logic          phv_valid_out;
  logic          phv_ready_in;
  logic          timeout_err;

  alu_dispatch #(
    .ACTION_LEN (AL),
    .DATA_WIDTH (W),
    .NUM_CONT   (N),
    .TIMEOUT    (TO)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .phv_in              (phv_in),
    .action_in           (action_in),
    .phv_valid_in        (phv_valid_in),
    .phv_ready_out       (phv_ready_out),
    .alu_action_out      (alu_action_out),
    .alu_action_valid    (alu_action_valid),
    .alu_op1_out         (alu_op1_out),
    .alu_op2_out         (alu_op2_out),
    .alu_op3_out         (alu_op3_out),
    .alu_op4_out         (alu_op4_out),
    .alu_ready_in        (alu_ready_in),
    .alu_result_in       (alu_result_in),
    .alu_result_valid_in (alu_result_valid_in),
    .alu_ready_out       (alu_ready_out),
    .phv_out             (phv_out),
    .phv_valid_out       (phv_valid_out),
    .phv_ready_in        (phv_ready_in),
    .timeout_err         (timeout_err)
  );

  always #5 clk = ~clk;

  int   n_cmp    = 0;
  int   n_bad    = 0;
  int   n_strobe = 0;
  logic exp_terr = 1'b0;

  // Count issue strobes, sampled mid-cycle.
  always @(negedge clk) if (alu_action_valid === 1'b1) n_strobe++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---- reference model -------------------------------------------------
  function automatic logic [AL-1:0] mk_act(input logic [7:0] opc, input logic [3:0] dst,
                                           input logic [3:0] s1, input logic [3:0] s2,
                                           input logic [3:0] s3, input logic [31:0] imm);
    return {opc, dst, s1, s2, s3, 8'h00, imm};
  endfunction

  function automatic logic [W-1:0] cont(input logic [PW-1:0] p, input logic [3:0] idx);
    int i;
    i = int'(idx) % N;
    return p[i*W +: W];
  endfunction

  function automatic logic [W-1:0] op2_ref(input logic [PW-1:0] p, input logic [AL-1:0] a);
    logic [7:0] opc;
    opc = a[63:56];
    if (opc == 8'h09 || opc == 8'h0A || opc == 8'h0E) return a[31:0];
    return cont(p, a[47:44]);
  endfunction

  // What the bench's stand-in ALU returns for a given action
  function automatic logic [W-1:0] alu_ref(input logic [PW-1:0] p, input logic [AL-1:0] a);
    case (a[63:56])
      8'h01:   return cont(p, a[51:48]) + cont(p, a[47:44]);
      8'h09:   return cont(p, a[51:48]) + a[31:0];
      default: return cont(p, a[51:48]) ^ op2_ref(p, a) ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  // Expected PHV leaving the dispatcher
  function automatic logic [PW-1:0] phv_ref(input logic [PW-1:0] p, input logic [AL-1:0] a,
                                            input logic [W-1:0] res, input logic got);
    logic [W-1:0]  c [N];
    logic [PW-1:0] q;
    for (int i = 0; i < N; i++) c[i] = p[i*W +: W];
    if (got && a[63:56] != 8'h00) c[int'(a[55:52]) % N] = res;
    for (int i = 0; i < N; i++) q[i*W +: W] = c[i];
    return q;
  endfunction

  // ---- one complete transaction ---------------------------------------
  // d: cycles alu_ready_in held low in ISSUE (stray results driven meanwhile)
  // k: WAIT cycle (1 = strobe cycle) carrying the result; 0 = never answer
  // s: cycles phv_ready_in held low in OUT (stray results driven meanwhile)
  task automatic run_txn(input string tag, input logic [PW-1:0] p, input logic [AL-1:0] a,
                         input int d, input int k, input int s);
    int            lat;
    int            w;
    int            st0;
    logic          got;
    logic [W-1:0]  res;
    logic [PW-1:0] exp_out;
    res = alu_ref(p, a);
    got = 1'b0;
    chk({tag, ".ready_idle"}, PW'(phv_ready_out), PW'(1'b1));
    phv_ready_in = 1'b0;
    alu_ready_in = 1'b0;
    phv_in       = p;
    action_in    = a;
    phv_valid_in = 1'b1;
    st0          = n_strobe;
    tick();
    phv_valid_in = 1'b0;
    phv_in       = ~p;
    action_in    = ~a;
    lat = 1;
    if (a[63:56] != 8'h00) begin
      chk({tag, ".ready_busy"}, PW'(phv_ready_out), PW'(1'b0));
      chk({tag, ".op1"}, PW'(alu_op1_out), PW'(cont(p, a[51:48])));
      chk({tag, ".op2"}, PW'(alu_op2_out), PW'(op2_ref(p, a)));
      chk({tag, ".op3"}, PW'(alu_op3_out), PW'(cont(p, a[43:40])));
      chk({tag, ".op4"}, PW'(alu_op4_out), PW'(0));
      chk({tag, ".action"}, PW'(alu_action_out), PW'(a));
      for (int i = 0; i < d; i++) begin
        alu_result_valid_in = 1'b1;
        alu_result_in       = $urandom;
        tick();
        lat++;
      end
      alu_result_valid_in = 1'b0;
      if (d > 0) begin
        chk({tag, ".no_strobe_held"}, PW'(n_strobe - st0), PW'(0));
        chk({tag, ".op2_held"}, PW'(alu_op2_out), PW'(op2_ref(p, a)));
      end
      alu_ready_in = 1'b1;
      tick();
      lat++;
      alu_ready_in = 1'b0;
      chk({tag, ".strobe"}, PW'(alu_action_valid), PW'(1'b1));
      chk({tag, ".alu_ready_out"}, PW'(alu_ready_out), PW'(1'b1));
      if (k > 0) begin
        for (int i = 1; i < k; i++) begin
          tick();
          lat++;
        end
        alu_result_valid_in = 1'b1;
        alu_result_in       = res;
        tick();
        lat++;
        alu_result_valid_in = 1'b0;
        got = 1'b1;
        // 3 cycles plus ALU latency (k-1) plus any issue back-pressure
        chk({tag, ".latency"}, PW'(lat), PW'(3 + d + (k - 1)));
      end else begin
        w = 0;
        while (phv_valid_out !== 1'b1 && w < TO + 10) begin
          tick();
          w++;
        end
        exp_terr = 1'b1;
        chk({tag, ".timeout_cycles"}, PW'(w), PW'(TO));
      end
    end
    exp_out = phv_ref(p, a, res, got);
    chk({tag, ".valid_out"}, PW'(phv_valid_out), PW'(1'b1));
    chk({tag, ".phv_out"}, phv_out, exp_out);
    chk({tag, ".timeout_err"}, PW'(timeout_err), PW'(exp_terr));
    chk({tag, ".ready_out_in_out"}, PW'(phv_ready_out), PW'(1'b0));
    for (int i = 0; i < s; i++) begin
      alu_result_valid_in = 1'b1;
      alu_result_in       = ~res;
      tick();
    end
    alu_result_valid_in = 1'b0;
    if (s > 0) begin
      chk({tag, ".stall_valid"}, PW'(phv_valid_out), PW'(1'b1));
      chk({tag, ".stall_phv"}, phv_out, exp_out);
      chk({tag, ".stall_ready"}, PW'(phv_ready_out), PW'(1'b0));
    end
    phv_ready_in = 1'b1;
    tick();
    phv_ready_in = 1'b0;
    chk({tag, ".valid_drop"}, PW'(phv_valid_out), PW'(1'b0));
    chk({tag, ".back_idle"}, PW'(phv_ready_out), PW'(1'b1));
    chk({tag, ".strobes"}, PW'(n_strobe - st0), PW'((a[63:56] == 8'h00) ? 0 : 1));
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PW-1:0] p;
    logic [AL-1:0] a;
    logic [7:0]    opc;

    rst = 1'b1; phv_in = '0; action_in = '0; phv_valid_in = 1'b0;
    alu_ready_in = 1'b0; alu_result_in = '0; alu_result_valid_in = 1'b0;
    phv_ready_in = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst.phv_ready_out", PW'(phv_ready_out), PW'(1'b1));
    chk("rst.alu_action_valid", PW'(alu_action_valid), PW'(1'b0));
    chk("rst.alu_ready_out", PW'(alu_ready_out), PW'(1'b0));
    chk("rst.phv_valid_out", PW'(phv_valid_out), PW'(1'b0));
    chk("rst.timeout_err", PW'(timeout_err), PW'(1'b0));
    chk("rst.phv_out", phv_out, PW'(0));

    // add: c0=5, c1=7 -> c2=12
    for (int i = 0; i < N; i++) p[i*W +: W] = $urandom;
    p[0*W +: W] = 32'd5;
    p[1*W +: W] = 32'd7;
    run_txn("add", p, mk_act(8'h01, 4'd2, 4'd0, 4'd1, 4'd3, 32'd0), 0, 1, 0);
    chk("add.c2_is_12", PW'(phv_out[2*W +: W]), PW'(32'd12));

    // addi: c0=1, imm=100 -> op2=100, dest gets 101
    p[0*W +: W] = 32'd1;
    run_txn("addi", p, mk_act(8'h09, 4'd5, 4'd0, 4'd1, 4'd2, 32'd100), 0, 2, 0);
    chk("addi.c5_is_101", PW'(phv_out[5*W +: W]), PW'(32'd101));

    // ALU busy for 10 cycles in ISSUE
    for (int i = 0; i < N; i++) p[i*W +: W] = $urandom;
    run_txn("busy10", p, mk_act(8'h0A, 4'd7, 4'd3, 4'd4, 4'd6, $urandom), 10, 3, 0);

    // Downstream stall 5 cycles with stray results
    run_txn("stall5", p, mk_act(8'h01, 4'd1, 4'd2, 4'd3, 4'd4, 32'd0), 0, 2, 5);

    // NOP: one-cycle pass-through
    run_txn("nop", p, mk_act(8'h00, 4'd3, 4'd1, 4'd1, 4'd1, $urandom), 0, 1, 2);

    // Result on the last allowed WAIT cycle is accepted without error
    run_txn("edge255", p, mk_act(8'h0E, 4'd4, 4'd9, 4'd10, 4'd11, $urandom), 0, TO, 0);

    // No result at all -> timeout, PHV unchanged, sticky error
    for (int i = 0; i < N; i++) p[i*W +: W] = $urandom;
    run_txn("timeout", p, mk_act(8'h01, 4'd6, 4'd0, 4'd1, 4'd2, 32'd0), 0, 0, 0);
    run_txn("after_to", p, mk_act(8'h01, 4'd6, 4'd0, 4'd1, 4'd2, 32'd0), 1, 1, 1);

    // Randomized transactions, indices 0..15 exercise the modulo reduction
    for (int t = 0; t < 24; t++) begin
      case ($urandom_range(0, 5))
        0:       opc = 8'h00;
        1:       opc = 8'h01;
        2:       opc = 8'h09;
        3:       opc = 8'h0A;
        4:       opc = 8'h0E;
        default: opc = 8'($urandom_range(16, 255));
      endcase
      for (int i = 0; i < N; i++) p[i*W +: W] = $urandom;
      a = mk_act(opc, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), $urandom);
      run_txn("rnd", p, a, $urandom_range(0, 3), $urandom_range(1, 4), $urandom_range(0, 2));
    end

    // Reset while waiting for the ALU discards the PHV
    for (int i = 0; i < N; i++) p[i*W +: W] = $urandom;
    phv_in       = p;
    action_in    = mk_act(8'h01, 4'd0, 4'd1, 4'd2, 4'd3, 32'd0);
    phv_valid_in = 1'b1;
    tick();
    phv_valid_in = 1'b0;
    alu_ready_in = 1'b1;
    tick();
    alu_ready_in = 1'b0;
    tick();
    chk("rstwait.in_wait", PW'(alu_ready_out), PW'(1'b1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_terr = 1'b0;
    chk("rstwait.phv_ready_out", PW'(phv_ready_out), PW'(1'b1));
    chk("rstwait.alu_action_valid", PW'(alu_action_valid), PW'(1'b0));
    chk("rstwait.alu_ready_out", PW'(alu_ready_out), PW'(1'b0));
    chk("rstwait.phv_valid_out", PW'(phv_valid_out), PW'(1'b0));
    chk("rstwait.timeout_err", PW'(timeout_err), PW'(1'b0));
    chk("rstwait.phv_out", phv_out, PW'(0));
    chk("rstwait.action_out", PW'(alu_action_out), PW'(0));
    alu_result_valid_in = 1'b1;
    alu_result_in       = 32'hDEAD_BEEF;
    phv_ready_in        = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    alu_result_valid_in = 1'b0;
    phv_ready_in        = 1'b0;
    chk("rstwait.no_emit", PW'(phv_valid_out), PW'(1'b0));
    chk("rstwait.phv_still_0", phv_out, PW'(0));

    run_txn("post_rst", p, mk_act(8'h09, 4'd3, 4'd2, 4'd0, 4'd1, 32'd77), 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_dispatch.md
ALU_DISPATCH -- requirements
Module: alu_dispatch

Interface
REQ-001 SHALL have parameter ACTION_LEN, default 64, width of one action word.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of one container and ALU operand.
REQ-003 SHALL have parameter NUM_CONT, default 8, number of PHV containers.
REQ-004 SHALL have parameter TIMEOUT, default 255, maximum cycles to wait for an ALU result.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 phv_in  in  NUM_CONT*DATA_WIDTH  input PHV; container i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 action_in  in  ACTION_LEN  action word for this PHV.
REQ-009 phv_valid_in  in  1  phv_in and action_in valid.
REQ-010 phv_ready_out  out  1  dispatcher accepts input.
REQ-011 alu_action_out  out  ACTION_LEN  action word to ALU.
REQ-012 alu_action_valid  out  1  one-cycle issue strobe to ALU.
REQ-013 alu_op1_out, alu_op2_out, alu_op3_out, alu_op4_out  out  DATA_WIDTH each  ALU operands.
REQ-014 alu_ready_in  in  1  ALU idle and able to accept an action.
REQ-015 alu_result_in  in  DATA_WIDTH  ALU container result.
REQ-016 alu_result_valid_in  in  1  one-cycle result strobe.
REQ-017 alu_ready_out  out  1  dispatcher able to take a result.
REQ-018 phv_out  out  NUM_CONT*DATA_WIDTH  updated PHV.
REQ-019 phv_valid_out  out  1  phv_out valid; held until phv_ready_in.
REQ-020 phv_ready_in  in  1  downstream accepts phv_out.
REQ-021 timeout_err  out  1  sticky; set on any ALU timeout, cleared only by rst.

Function
REQ-022 Action decode SHALL be: opcode [63:56], dest index [55:52], src1 [51:48], src2 [47:44], src3 [43:40], immediate [31:0]; indices taken modulo NUM_CONT.
REQ-023 op1 SHALL be container[src1]; op3 SHALL be container[src3]; op4 SHALL be 0.
REQ-024 op2 SHALL be the immediate for opcodes 8'h09, 8'h0A, 8'h0E, else container[src2].
REQ-025 FSM states SHALL be IDLE, ISSUE, WAIT, OUT.
REQ-026 IDLE: phv_ready_out=1; on phv_valid_in SHALL capture PHV and action, go to ISSUE; opcode 8'h00 (NOP) SHALL go directly to OUT with PHV unchanged.
REQ-027 ISSUE: SHALL hold operands stable; when alu_ready_in=1, SHALL assert alu_action_valid exactly one cycle and go to WAIT.
REQ-028 WAIT: alu_ready_out=1; on alu_result_valid_in SHALL write alu_result_in into container[dest] and go to OUT.
REQ-029 WAIT SHALL count cycles from entry; reaching TIMEOUT without result SHALL set timeout_err and go to OUT with PHV unchanged.
REQ-030 alu_result_valid_in outside WAIT SHALL be ignored.
REQ-031 OUT: phv_valid_out=1; on phv_ready_in SHALL return to IDLE; phv_out stable while stalled.
REQ-032 Minimum latency accept-to-phv_valid_out SHALL be 3 cycles plus ALU latency; NOP SHALL be 1 cycle.
REQ-033 Only one PHV SHALL be in flight; phv_ready_out=0 outside IDLE.
REQ-034 Result arriving on the same cycle the counter reaches TIMEOUT SHALL be taken as a valid result, no error.

Reset
REQ-035 On rst: state IDLE, phv_ready_out=1, alu_action_valid=0, alu_ready_out=0, phv_valid_out=0, timeout_err=0, all data registers 0.
REQ-036 rst mid-operation SHALL discard the in-flight PHV without emitting it.

Structure
REQ-037 Opcode constants, field offsets and FSM state encodings SHALL live in a shared action package.
REQ-038 Operand selection SHALL be one sub-module, operand_mux (PHV + indices + opcode -> four operands, combinational).

Verification
REQ-039 add 8'h01, src1=0 (5), src2=1 (7), dest=2, ALU returns 12 -> container2=12, others unchanged.
REQ-040 addi 8'h09, imm=100, container0=1 -> alu_op2_out=100 at issue; result 101 written to dest.
REQ-041 alu_ready_in low 10 cycles in ISSUE -> no alu_action_valid until it rises; single strobe after.
REQ-042 No result for 255 cycles -> timeout_err=1, phv_out equals phv_in; next PHV processes normally.
REQ-043 phv_ready_in low 5 cycles in OUT -> phv_out stable, phv_ready_out=0, stray alu_result_valid_in ignored.
REQ-044 rst asserted in WAIT -> all outputs at reset values next cycle, no phv_valid_out for discarded PHV.
